// File: rtl/sensor_debounce.sv
// Four-channel proximity sensor debouncer.
// Each raw input is synchronized into the clk domain and then has to disagree
// with the current debounced level for DEBOUNCE_CYCLES consecutive cycles
// before that level is allowed to change. A single pulse on sensor_changed
// flags every edge on which any debounced output updates.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic front_raw,
    input  logic left_raw,
    input  logic right_raw,
    input  logic back_raw,
    output logic front_sensor,
    output logic left_sensor,
    output logic right_sensor,
    output logic back_sensor,
    output logic sensor_changed
);

    // The counter value at which the next disagreeing sample commits the change.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order in every vector: [0]=front, [1]=left, [2]=right, [3]=back.
    logic [3:0] raw_vec;
    logic [3:0] sync_meta;
    logic [3:0] sync_s;
    logic [3:0] stable;
    logic [3:0] update;

    assign raw_vec = {back_raw, right_raw, left_raw, front_raw};

    // Two-flop synchronizer; the first stage may go metastable and is never
    // used by anything except the second stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= raw_vec;
            sync_s    <= sync_meta;
        end
    end

    // One independent counter and stable register per channel.
    for (genvar ch = 0; ch < 4; ch++) begin : g_chan
        logic [CNT_W-1:0] cnt;
        logic             stable_q;

        // A channel commits when its synced value still disagrees after the
        // counter has already seen DEBOUNCE_CYCLES-1 disagreeing cycles.
        always_comb begin
            update[ch] = (sync_s[ch] != stable_q) && (cnt == CNT_LAST);
        end

        // Count consecutive disagreeing cycles, restart on agreement, and
        // clear on commit so the counter never passes CNT_LAST or wraps.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt      <= '0;
                stable_q <= 1'b0;
            end else if (sync_s[ch] == stable_q) begin
                cnt <= '0;
            end else if (update[ch]) begin
                cnt      <= '0;
                stable_q <= sync_s[ch];
            end else if (cnt < CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign stable[ch] = stable_q;
    end

    // Registered alongside the stable levels so the pulse lines up with the
    // first cycle in which any new debounced value is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sensor_changed <= 1'b0;
        end else begin
            sensor_changed <= |update;
        end
    end

    assign front_sensor = stable[0];
    assign left_sensor  = stable[1];
    assign right_sensor = stable[2];
    assign back_sensor  = stable[3];

endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce: two instances (DEBOUNCE_CYCLES = 8 and 2) share
// the same raw inputs. A window-based reference model predicts every output on
// every cycle, and directed scenarios pin the model with hand-derived values.
module tb_sensor_debounce;

    logic       clk;
    logic       reset;
    logic [3:0] raw;
    logic [3:0] out8;
    logic [3:0] out2;
    logic       chg8;
    logic       chg2;

    int total = 0;
    int bad   = 0;

    // Reference model state, indexed [0] = 8-cycle instance, [1] = 2-cycle.
    logic [3:0] samp_q[$];
    int         edge_k;
    logic [3:0] stable_m [2];
    logic       changed_m [2];

    sensor_debounce #(.DEBOUNCE_CYCLES(8), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset),
        .front_raw(raw[0]), .left_raw(raw[1]), .right_raw(raw[2]), .back_raw(raw[3]),
        .front_sensor(out8[0]), .left_sensor(out8[1]),
        .right_sensor(out8[2]), .back_sensor(out8[3]),
        .sensor_changed(chg8)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(2), .CNT_W(8)) dut2 (
        .clk(clk), .reset(reset),
        .front_raw(raw[0]), .left_raw(raw[1]), .right_raw(raw[2]), .back_raw(raw[3]),
        .front_sensor(out2[0]), .left_sensor(out2[1]),
        .right_sensor(out2[2]), .back_sensor(out2[3]),
        .sensor_changed(chg2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synced value seen before edge j (1-based since reset): the raw sample
    // taken two edges earlier, or zero while the synchronizer is still filling.
    function automatic logic [3:0] sync_at(int j);
        if (j >= 3 && (j - 3) < samp_q.size()) return samp_q[j-3];
        return 4'b0000;
    endfunction

    // Reference model: a channel updates on edge k when the synced values of
    // the last D edges all disagree with its current debounced level.
    initial begin
        stable_m[0] = '0; stable_m[1] = '0;
        changed_m[0] = 1'b0; changed_m[1] = 1'b0;
        edge_k = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                samp_q.delete();
                edge_k = 0;
                stable_m[0] = '0; stable_m[1] = '0;
                changed_m[0] = 1'b0; changed_m[1] = 1'b0;
            end else begin
                edge_k++;
                for (int inst = 0; inst < 2; inst++) begin
                    int d;
                    logic [3:0] next_v;
                    logic any;
                    d = (inst == 0) ? 8 : 2;
                    next_v = stable_m[inst];
                    any = 1'b0;
                    for (int ch = 0; ch < 4; ch++) begin
                        logic all_diff;
                        logic [3:0] sv;
                        all_diff = 1'b1;
                        for (int j = edge_k - d + 1; j <= edge_k; j++) begin
                            sv = sync_at(j);
                            if (sv[ch] == stable_m[inst][ch]) all_diff = 1'b0;
                        end
                        if (all_diff) begin
                            next_v[ch] = ~stable_m[inst][ch];
                            any = 1'b1;
                        end
                    end
                    stable_m[inst]  = next_v;
                    changed_m[inst] = any;
                end
                samp_q.push_back(raw);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] actual,
                               input logic [3:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v);
        raw = v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Continuous comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model_out8", out8, stable_m[0]);
            checkOutput("model_chg8", {3'b000, chg8}, {3'b000, changed_m[0]});
            checkOutput("model_out2", out2, stable_m[1]);
            checkOutput("model_chg2", {3'b000, chg2}, {3'b000, changed_m[1]});
        end
    end

    initial begin
        int pulses;
        logic lvl;
        int hold [4];
        logic [3:0] rv;

        reset = 1'b1;
        raw   = 4'b0000;
        wait_cycles(3);
        checkOutput("reset_out8", out8, 4'b0000);
        checkOutput("reset_chg8", {3'b000, chg8}, 4'b0000);
        reset = 1'b0;
        wait_cycles(5);

        // Front rises and is held: visible after edge 10, one pulse.
        applyStimulus(4'b0001);
        wait_cycles(9);
        checkOutput("front_edge9", {3'b000, out8[0]}, 4'b0000);
        wait_cycles(1);
        checkOutput("front_edge10", {3'b000, out8[0]}, 4'b0001);
        checkOutput("front_pulse", {3'b000, chg8}, 4'b0001);
        wait_cycles(1);
        checkOutput("front_pulse_end", {3'b000, chg8}, 4'b0000);

        // Five-cycle left glitch must be rejected by the 8-cycle instance.
        applyStimulus(4'b0011);
        wait_cycles(5);
        applyStimulus(4'b0001);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            wait_cycles(1);
            if (chg8) pulses++;
        end
        checkOutput("glitch_left", {3'b000, out8[1]}, 4'b0000);
        checkOutput("glitch_pulses", 4'(pulses), 4'd0);

        // Right and back rise together: one shared update and pulse.
        applyStimulus(4'b1101);
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            wait_cycles(1);
            if (chg8) pulses++;
            if (i == 9)  checkOutput("pair_edge9", out8, 4'b0001);
            if (i == 10) checkOutput("pair_edge10", out8, 4'b1101);
        end
        checkOutput("pair_pulses", 4'(pulses), 4'd1);

        // Front low 7, high 1, low held: falls only after 8 steady low syncs.
        applyStimulus(4'b1100);
        wait_cycles(7);
        applyStimulus(4'b1101);
        wait_cycles(1);
        applyStimulus(4'b1100);
        wait_cycles(9);
        checkOutput("restart_edge17", {3'b000, out8[0]}, 4'b0001);
        wait_cycles(1);
        checkOutput("restart_edge18", {3'b000, out8[0]}, 4'b0000);
        checkOutput("restart_pulse", {3'b000, chg8}, 4'b0001);

        // Async reset while the back channel is mid-count.
        applyStimulus(4'b0000);
        wait_cycles(12);
        applyStimulus(4'b0001);
        wait_cycles(12);
        applyStimulus(4'b1001);
        wait_cycles(8);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_out8", out8, 4'b0000);
        checkOutput("async_out2", out2, 4'b0000);
        checkOutput("async_chg", {2'b00, chg2, chg8}, 4'b0000);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(3);
        checkOutput("rel2_edge3", out2, 4'b0000);
        wait_cycles(1);
        checkOutput("rel2_edge4", out2, 4'b1001);
        wait_cycles(5);
        checkOutput("rel8_edge9", out8, 4'b0000);
        wait_cycles(1);
        checkOutput("rel8_edge10", out8, 4'b1001);
        checkOutput("rel8_pulse", {3'b000, chg8}, 4'b0001);

        // Toggle right every 3 cycles: the 2-cycle instance follows each
        // toggle after its 4th edge with one pulse.
        applyStimulus(4'b0000);
        wait_cycles(15);
        lvl = 1'b0;
        for (int t = 0; t < 6; t++) begin
            lvl = ~lvl;
            applyStimulus({1'b0, lvl, 2'b00});
            wait_cycles(1);
            if (t > 0) begin
                checkOutput("toggle_follow", {3'b000, out2[2]}, {3'b000, ~lvl});
                checkOutput("toggle_pulse", {3'b000, chg2}, 4'b0001);
            end
            wait_cycles(2);
            checkOutput("toggle_hold", {3'b000, out2[2]}, {3'b000, ~lvl});
        end
        wait_cycles(1);
        checkOutput("toggle_last", {3'b000, out2[2]}, {3'b000, lvl});

        // Randomized run-lengths around the debounce window, with occasional
        // asynchronous resets; the model comparison checks every cycle.
        rv = raw;
        for (int ch = 0; ch < 4; ch++) hold[ch] = int'($urandom_range(1, 12));
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (hold[ch] == 0) begin
                    rv[ch] = ~rv[ch];
                    hold[ch] = int'($urandom_range(1, 12));
                end else begin
                    hold[ch]--;
                end
            end
            applyStimulus(rv);
            if (i % 300 == 299) begin
                #($urandom_range(1, 3));
                reset = 1'b1;
                wait_cycles(2);
                reset = 1'b0;
            end else begin
                wait_cycles(1);
            end
        end
        wait_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
